ps2_rx_fifo: RTL and testbench



---
 rtl/ps2_rx_fifo.sv | 161 ++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 receiver: sync/filter, deframe, parity check, FWFT scancode FIFO
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        ren,
  output logic [15:0] data_out
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLT_LAST = FILTER_LEN - 1;
  localparam int TMO_LAST = TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // index 0 is the PS/2 clock line, index 1 the data line
  logic [1:0]    raw;
  logic [1:0]    sync1, sync2, filt;
  logic [CW-1:0] fcnt [2];
  logic          filt_clk_q;
  logic          fall;

  state_t        state, state_n;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          push, ferr_evt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, valid, pop, push_ok, ovf_evt;
  logic          ovf_flag, ferr_flag;

  assign raw = {ps2_data, ps2_clk};

  // two-flop synchroniser, then a line only flips after FILTER_LEN agreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      filt_clk_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      filt_clk_q <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FLT_LAST[CW-1:0]) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall    = filt_clk_q & ~filt[0];
  assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt == TMO_LAST[TW-1:0]);

  // deframe state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // deframe next state; a stalled frame is abandoned before any edge is considered
  always_comb begin
    state_n  = state;
    push     = 1'b0;
    ferr_evt = 1'b0;
    if (tmo_hit) begin
      state_n  = IDLE;
      ferr_evt = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:    if (!filt[1]) state_n = DATA;
        DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (filt[1] && (^{shreg, par_bit})) push = 1'b1;
          else                                 ferr_evt = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // frame datapath: bit shifter, parity capture, inter-edge timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (fall || state == IDLE || tmo_hit) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + 1'b1;
      if (fall && !tmo_hit) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shreg   <= {filt[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  par_bit <= filt[1];
          default: ;
        endcase
      end
    end
  end

  assign full    = (count == FIFO_DEPTH[PW:0]);
  assign valid   = (count != '0);
  assign pop     = ren && valid;
  assign push_ok = push && (!full || pop);
  assign ovf_evt = push && full && !pop;

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, occupancy and sticky flags (a set event beats the ren clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf_flag  <= 1'b0;
      ferr_flag <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ovf_flag  <= ovf_evt  | (ovf_flag  & ~ren);
      ferr_flag <= ferr_evt | (ferr_flag & ~ren);
    end
  end

  assign data_out = {valid, ovf_flag, ferr_flag, 5'b00000, valid ? mem[rd_ptr] : 8'h00};

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - randomized self-checking bench for ps2_rx_fifo with queue reference model
module tb_ps2_rx_fifo;

  localparam int DEPTH = 16;
  localparam int FLT   = 4;
  localparam int TMO   = 2000;
  localparam int HALF  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        ren = 1'b0;
  logic [15:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q [$];
  logic       m_ovf = 1'b0;
  logic       m_ferr = 1'b0;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ren(ren), .data_out(data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_dout();
    logic [7:0] b;
    b = (q.size() != 0) ? q[0] : 8'h00;
    return {q.size() != 0, m_ovf, m_ferr, 5'b00000, b};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  // full device-to-host frame; ren_stop pulses ren on the cycle the stop edge pushes
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input logic ren_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_data = ~bad_stop;
    tick(HALF);
    ps2_clk = 1'b0;
    if (ren_stop) begin
      tick(2 + FLT);
      ren = 1'b1;
      tick(1);
      ren = 1'b0;
      tick(HALF - 3 - FLT);
    end else begin
      tick(HALF);
    end
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick(HALF);
    if (!ren_stop) begin
      if (bad_par || bad_stop) m_ferr = 1'b1;
      else if (q.size() < DEPTH) q.push_back(b);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic do_read(input string tag);
    check({tag, "_pre"}, data_out, model_dout());
    ren = 1'b1;
    tick(1);
    ren = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    check({tag, "_post"}, data_out, model_dout());
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    check("reset", data_out, 16'h0000);

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("good_1c", data_out, 16'h801C);
    do_read("rd_1c");
    check("after_rd_1c", data_out, 16'h0000);

    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check("bad_parity", data_out, 16'h2000);
    do_read("rd_perr");

    for (int i = 1; i <= 17; i++) send_frame(i[7:0], 1'b0, 1'b0, 1'b0);
    check("overflow", data_out, 16'hC001);
    for (int i = 0; i < 16; i++) do_read("drain17");
    check("drained", data_out, 16'h0000);

    for (int i = 0; i < 16; i++) send_frame(8'h30 + i[7:0], 1'b0, 1'b0, 1'b0);
    check("full16", data_out, 16'h8030);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
    void'(q.pop_front());
    q.push_back(8'hAA);
    check("push_pop_full", data_out, 16'h8031);
    for (int i = 0; i < 16; i++) do_read("drain_aa");
    check("aa_last", data_out, 16'h0000);

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    tick(TMO + 10);
    m_ferr = 1'b1;
    check("timeout_flag", data_out, 16'h2000);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check("timeout_then_f0", data_out, 16'hA0F0);
    do_read("rd_f0");

    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0]);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    check("mid_reset", data_out, 16'h0000);
    for (int i = 0; i < 5; i++) ps2_bit(i[1]);
    tick(TMO + 10);
    ren = 1'b1;
    tick(1);
    ren = 1'b0;
    check("tail_cleared", data_out, 16'h0000);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check("after_reset_5a", data_out, 16'h805A);
    do_read("rd_5a");

    for (int n = 0; n < 24; n++) begin
      int op;
      logic [7:0] b;
      op = $urandom_range(0, 5);
      b = 8'($urandom);
      case (op)
        0, 1, 2: send_frame(b, 1'b0, 1'b0, 1'b0);
        3:       send_frame(b, 1'b1, 1'b0, 1'b0);
        4:       send_frame(b, 1'b0, 1'b1, 1'b0);
        default: do_read("rand_rd");
      endcase
      check("rand_state", data_out, model_dout());
    end
    while (q.size() != 0) do_read("rand_drain");
    do_read("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
